// File: rtl/hilo_md_unit.sv
// -----------------------------------------------------------------------------
// hilo_md_unit
//   Multi-cycle multiply/divide sequencer owning the architectural HI/LO
//   registers. A start strobe latches operand magnitudes and runs ITER
//   iterations of shift-add multiply or restoring divide (CALC), then a single
//   FIX cycle applies sign correction and commits HI/LO. Moves and reads are
//   served directly; any strobe presented while busy stalls the pipeline.
//
// Ports
//   clk            core clock, rising edge
//   rst            asynchronous reset, active low
//   mult/multu     start signed/unsigned multiply (rs * rt)
//   div/divu       start signed/unsigned divide   (rs / rt)
//   mthi/mtlo      write rs to HI/LO
//   mfhi/mflo      read HI/LO onto hilo_rdata
//   rs, rt         32-bit operands
//   hilo_rdata     HI on mfhi, LO on mflo, else 0 (combinational)
//   stall          busy and a strobe is present (combinational)
//   busy           an operation is in flight (registered)
//   hi, lo         architectural HI and LO
// -----------------------------------------------------------------------------
module hilo_md_unit #(
   parameter int ITER = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mult,
   input  logic        multu,
   input  logic        div,
   input  logic        divu,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic        mfhi,
   input  logic        mflo,
   input  logic [31:0] rs,
   input  logic [31:0] rt,
   output logic [31:0] hilo_rdata,
   output logic        stall,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [63:0]     acc_q, acc_d;    // mult: {partial, multiplier}; div: {remainder, quotient}
   logic [31:0]     a_q, a_d;        // |rs| (multiplicand or dividend)
   logic [31:0]     b_q, b_d;        // |rt| (multiplier or divisor)
   logic            is_div_q, is_div_d;
   logic            sgn_a_q, sgn_a_d; // only ever set for signed ops
   logic            sgn_b_q, sgn_b_d;
   logic            busy_q, busy_d;
   logic [31:0]     hi_q, hi_d;
   logic [31:0]     lo_q, lo_d;

   // Start decode with mult > multu > div > divu priority.
   logic        start, op_signed, op_div, rs_neg, rt_neg, accept;
   logic [31:0] rs_mag, rt_mag;

   assign start     = mult | multu | div | divu;
   assign op_signed = mult | (~multu & div);
   assign op_div    = ~mult & ~multu & (div | divu);
   assign rs_neg    = op_signed & rs[31];
   assign rt_neg    = op_signed & rt[31];
   assign rs_mag    = rs_neg ? -rs : rs;
   assign rt_mag    = rt_neg ? -rt : rt;
   // FIX also accepts, so a held strobe is taken on the commit edge without a bubble.
   assign accept    = (state_q == S_IDLE) || (state_q == S_FIX);

   // Multiply step: add multiplicand on the LSB of the multiplier, shift right.
   logic [32:0] add_sum;
   logic [63:0] mul_next;
   assign add_sum  = {1'b0, acc_q[63:32]} + (acc_q[0] ? {1'b0, a_q} : 33'd0);
   assign mul_next = {add_sum, acc_q[31:1]};

   // Restoring divide step: shift in next dividend bit, subtract if it fits.
   // The remainder stays below the divisor, so the difference fits in 32 bits.
   logic [32:0] rem_sh;
   logic        fits;
   logic [31:0] diff;
   logic [63:0] div_next;
   assign rem_sh   = {acc_q[63:32], acc_q[31]};
   assign fits     = rem_sh >= {1'b0, b_q};
   assign diff     = rem_sh[31:0] - b_q;
   assign div_next = fits ? {diff, acc_q[30:0], 1'b1} : {rem_sh[31:0], acc_q[30:0], 1'b0};

   logic [63:0] prod_fixed;
   assign prod_fixed = (sgn_a_q ^ sgn_b_q) ? -acc_q : acc_q;

   always_comb begin
      // NOTE: every always_comb target gets a default first; a path that skips an assignment would otherwise infer a latch.
      state_d  = state_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      a_d      = a_q;
      b_d      = b_q;
      is_div_d = is_div_q;
      sgn_a_d  = sgn_a_q;
      sgn_b_d  = sgn_b_q;
      busy_d   = busy_q;
      hi_d     = hi_q;
      lo_d     = lo_q;

      case (state_q)
         S_CALC: begin
            acc_d = is_div_q ? div_next : mul_next;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) state_d = S_FIX;
         end
         S_FIX: begin
            if (is_div_q) begin
               if (b_q == '0) begin
                  // Divide by zero: rebuild the original rs from its magnitude.
                  lo_d = 32'hFFFF_FFFF;
                  hi_d = sgn_a_q ? -a_q : a_q;
               end else begin
                  lo_d = (sgn_a_q ^ sgn_b_q) ? -acc_q[31:0] : acc_q[31:0];
                  hi_d = sgn_a_q ? -acc_q[63:32] : acc_q[63:32];
               end
            end else begin
               {hi_d, lo_d} = prod_fixed;
            end
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: ;
      endcase

      // A later move overrides the commit it lands on; a start outranks moves.
      if (accept) begin
         if (start) begin
            a_d      = rs_mag;
            b_d      = rt_mag;
            acc_d    = op_div ? {32'd0, rs_mag} : {32'd0, rt_mag};
            is_div_d = op_div;
            sgn_a_d  = rs_neg;
            sgn_b_d  = rt_neg;
            cnt_d    = '0;
            state_d  = S_CALC;
            busy_d   = 1'b1;
         end else begin
            if (mthi) hi_d = rs;
            if (mtlo) lo_d = rs;
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         acc_q    <= '0;
         a_q      <= '0;
         b_q      <= '0;
         is_div_q <= 1'b0;
         sgn_a_q  <= 1'b0;
         sgn_b_q  <= 1'b0;
         busy_q   <= 1'b0;
         hi_q     <= '0;
         lo_q     <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         a_q      <= a_d;
         b_q      <= b_d;
         is_div_q <= is_div_d;
         sgn_a_q  <= sgn_a_d;
         sgn_b_q  <= sgn_b_d;
         busy_q   <= busy_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
      end
   end

   assign busy       = busy_q;
   assign hi         = hi_q;
   assign lo         = lo_q;
   assign stall      = busy_q & (start | mthi | mtlo | mfhi | mflo);
   assign hilo_rdata = mfhi ? hi_q : (mflo ? lo_q : 32'd0);

endmodule

// File: tb/tb_hilo_md_unit.sv
// -----------------------------------------------------------------------------
// tb_hilo_md_unit
//   Directed bench for hilo_md_unit. A behavioural model computes HI/LO with
//   plain 64-bit arithmetic and tracks the 33-edge latency as a countdown; a
//   compare process checks every DUT output against it on each falling edge.
//   Literal expectations from hand calculation pin the model.
// -----------------------------------------------------------------------------
module tb_hilo_md_unit;

   logic        clk = 1'b0;
   logic        rst;
   logic        mult, multu, div, divu, mthi, mtlo, mfhi, mflo;
   logic [31:0] rs, rt;
   logic [31:0] hilo_rdata, hi, lo;
   logic        stall, busy;

   int n_cmp = 0;
   int n_bad = 0;

   hilo_md_unit #(.ITER(32)) dut (
      .clk(clk), .rst(rst),
      .mult(mult), .multu(multu), .div(div), .divu(divu),
      .mthi(mthi), .mtlo(mtlo), .mfhi(mfhi), .mflo(mflo),
      .rs(rs), .rt(rt),
      .hilo_rdata(hilo_rdata), .stall(stall), .busy(busy),
      .hi(hi), .lo(lo)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h, expected %08h at t=%0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic void ref_op(input int k, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] h, output logic [31:0] l);
      logic [63:0] u;
      longint      q, r;
      h = '0; l = '0;
      case (k)
         0: begin u = longint'($signed(a)) * longint'($signed(b)); h = u[63:32]; l = u[31:0]; end
         1: begin u = {32'd0, a} * {32'd0, b};                     h = u[63:32]; l = u[31:0]; end
         default: begin
            if (b == 32'd0) begin
               h = a; l = 32'hFFFF_FFFF;
            end else if (k == 2) begin
               q = longint'($signed(a)) / longint'($signed(b));
               r = longint'($signed(a)) % longint'($signed(b));
               u = q; l = u[31:0];
               u = r; h = u[31:0];
            end else begin
               l = a / b; h = a % b;
            end
         end
      endcase
   endfunction

   logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
   logic        m_busy = 1'b0;
   int          m_left = 0;

   always @(posedge clk or negedge rst) begin : model_p
      logic [31:0] nh, nl, ph, pl;
      logic        nb;
      int          nleft;
      if (!rst) begin
         m_hi <= '0; m_lo <= '0; m_busy <= 1'b0; m_left <= 0;
      end else begin
         nh = m_hi; nl = m_lo; ph = p_hi; pl = p_lo; nb = m_busy; nleft = m_left;
         if (nb) begin
            nleft = nleft - 1;
            if (nleft == 0) begin nh = ph; nl = pl; nb = 1'b0; end
         end
         if (!nb) begin
            if (mult | multu | div | divu) begin
               ref_op(mult ? 0 : multu ? 1 : div ? 2 : 3, rs, rt, ph, pl);
               nb = 1'b1; nleft = 33;
            end else begin
               if (mthi) nh = rs;
               if (mtlo) nl = rs;
            end
         end
         m_hi <= nh; m_lo <= nl; p_hi <= ph; p_lo <= pl; m_busy <= nb; m_left <= nleft;
      end
   end

   always @(negedge clk) begin
      logic any_strobe;
      any_strobe = mult | multu | div | divu | mthi | mtlo | mfhi | mflo;
      check("model_hi",    hi,               m_hi);
      check("model_lo",    lo,               m_lo);
      check("model_busy",  {31'd0, busy},    {31'd0, m_busy});
      check("model_stall", {31'd0, stall},   {31'd0, m_busy & any_strobe});
      check("model_rdata", hilo_rdata,       mfhi ? m_hi : (mflo ? m_lo : 32'd0));
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      {mult, multu, div, divu, mthi, mtlo, mfhi, mflo} = '0;
   endtask

   task automatic start(input int k, input logic [31:0] a, input logic [31:0] b);
      clr();
      mult = (k == 0); multu = (k == 1); div = (k == 2); divu = (k == 3);
      rs = a; rt = b;
      tick();
      clr();
   endtask

   // Counts falling edges with busy high, starting in the cycle after the start edge.
   task automatic count_busy(output int n);
      n = 0;
      @(negedge clk);
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
   endtask

   task automatic run_op(input string name, input int k, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
      int n;
      start(k, a, b);
      count_busy(n);
      check({name, "_busy_cycles"}, n, 33);
      check({name, "_hi"}, hi, exp_hi);
      check({name, "_lo"}, lo, exp_lo);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      rst = 1'b0;
      clr();
      rs = '0; rt = '0;
      repeat (3) tick();
      @(negedge clk);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      tick();

      // Reset in the middle of an operation discards it.
      rs = 32'h22; mtlo = 1'b1; tick(); clr();
      @(negedge clk);
      check("pre_reset_lo", lo, 32'h22);
      @(posedge clk); #1;
      start(0, 32'd5, 32'd7);
      repeat (9) tick();
      #2 rst = 1'b0;
      @(negedge clk);
      check("midrst_hi", hi, 32'd0);
      check("midrst_lo", lo, 32'd0);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;
      rst = 1'b1;
      repeat (40) tick();
      @(negedge clk);
      check("midrst_late_hi", hi, 32'd0);
      check("midrst_late_lo", lo, 32'd0);
      @(posedge clk); #1;

      // Signed multiply with mflo held: stalls through E33, then reads new LO.
      start(0, 32'hFFFF_FFFD, 32'd7);
      mflo = 1'b1;
      for (int i = 0; i < 33; i++) begin
         @(negedge clk);
         check("mult_stall_held", {31'd0, stall}, 32'd1);
         @(posedge clk); #1;
      end
      @(negedge clk);
      check("mult_rdata_after", hilo_rdata, 32'hFFFF_FFEB);
      check("mult_stall_after", {31'd0, stall}, 32'd0);
      check("mult_hi", hi, 32'hFFFF_FFFF);
      @(posedge clk); #1;
      clr();

      run_op("multu_max", 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
      run_op("div_neg",   2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_100",  3, 32'd100,       32'd7,         32'd2,         32'd14);
      run_op("div_zero",  2, 32'h1234,      32'd0,         32'h1234,      32'hFFFF_FFFF);
      run_op("divu_zero", 3, 32'h8000_0001, 32'd0,         32'h8000_0001, 32'hFFFF_FFFF);
      run_op("div_ovf",   2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000);
      run_op("mult_nn",   0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0);
      run_op("div_mix",   2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD);
      @(posedge clk); #1;

      // mthi then mfhi next cycle.
      rs = 32'hA5A5_A5A5; mthi = 1'b1; tick(); clr();
      mfhi = 1'b1;
      @(negedge clk);
      check("mthi_mfhi_rdata", hilo_rdata, 32'hA5A5_A5A5);
      check("mthi_mfhi_stall", {31'd0, stall}, 32'd0);
      @(posedge clk); #1;

      // Move and read together: read sees the old value.
      rs = 32'h77; mthi = 1'b1; mfhi = 1'b1;
      @(negedge clk);
      check("mv_rd_old", hilo_rdata, 32'hA5A5_A5A5);
      @(posedge clk); #1;
      clr();
      @(negedge clk);
      check("mv_rd_new_hi", hi, 32'h77);
      @(posedge clk); #1;

      // mtlo during busy stalls until E33, then overrides LO.
      start(3, 32'd100, 32'd7);
      rs = 32'hCAFE; mtlo = 1'b1;
      n = 0;
      @(negedge clk);
      while (stall && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("mtlo_busy_stall_cycles", n, 33);
      check("mtlo_busy_lo", lo, 32'hCAFE);
      check("mtlo_busy_hi", hi, 32'd2);
      @(posedge clk); #1;
      clr();

      // Start and move together in IDLE: only the multiply starts.
      mult = 1'b1; mthi = 1'b1; rs = 32'd3; rt = 32'd4;
      tick(); clr();
      @(negedge clk);
      check("arb_busy", {31'd0, busy}, 32'd1);
      check("arb_hi_untouched", hi, 32'd2);
      @(posedge clk); #1;
      repeat (32) tick();
      @(negedge clk);
      check("arb_hi", hi, 32'd0);
      check("arb_lo", lo, 32'd12);
      check("arb_idle", {31'd0, busy}, 32'd0);
      @(posedge clk); #1;

      // Back-to-back: second start accepted on the commit edge.
      start(1, 32'd2, 32'd3);
      repeat (32) tick();
      divu = 1'b1; rs = 32'd9; rt = 32'd2;
      tick(); clr();
      @(negedge clk);
      check("b2b_busy", {31'd0, busy}, 32'd1);
      check("b2b_first_lo", lo, 32'd6);
      n = 0;
      while (busy && n < 100) begin
         n++;
         @(negedge clk);
      end
      check("b2b_busy_cycles", n, 33);
      check("b2b_hi", hi, 32'd1);
      check("b2b_lo", lo, 32'd4);

      @(posedge clk); #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/hilo_md_unit.md
# hilo_md_unit

Multi-cycle multiply/divide sequencer that owns the HI and LO registers. It accepts the decoder's `mult`, `multu`, `div`, `divu`, `mthi`, `mtlo`, `mfhi` and `mflo` strobes, using rs (`rs2hilo`) and rt (`rt2cp0`) as operands. It runs a 32-iteration shift-add multiply or restoring divide, and stalls the pipeline while a result is pending. Its read mux drives the `rdfcp0` return path for `mfhi`/`mflo`.

## Interface
Parameters:
- `ITER`, default 32: iteration count per operation. Fixed at 32 for the 32-bit datapath.

Ports:
- `clk`, input, 1: core clock. All state changes on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `mult`, `multu`, `div`, `divu`, input, 1 each: start signed/unsigned multiply or divide.
- `mthi`, `mtlo`, input, 1 each: write rs to HI or LO.
- `mfhi`, `mflo`, input, 1 each: read HI or LO.
- `rs`, input, 32: operand A, dividend, or mthi/mtlo data.
- `rt`, input, 32: operand B or divisor.
- `hilo_rdata`, output, 32: HI when `mfhi`, LO when `mflo`, otherwise 0. Combinational.
- `stall`, output, 1: the pipeline must hold the current instruction. Combinational.
- `busy`, output, 1: an operation is in flight. Registered.
- `hi`, `lo`, output, 32 each: architectural HI and LO registers.

## Operation
- States:
  - IDLE: no operation in flight.
  - CALC: 32 iterations; counter runs 0..31.
  - FIX: applies sign correction and commits HI/LO.
- IDLE behaviour:
  - Operation start: on the first asserted of `mult`>`multu`>`div`>`divu`, latch |rs| and |rt|. Magnitude is taken only for the signed ops. Latch the sign flags, clear the counter and go to CALC.
  - Moves: otherwise `mthi` writes HI = rs and `mtlo` writes LO = rs at the edge. A start strobe in the same cycle outranks a move.
- Multiply: shift-add on a 64-bit accumulator, one partial product per CALC cycle.
  - FIX negates the 64-bit result when sign(rs) xor sign(rt) and the op is signed.
  - HI = [63:32], LO = [31:0].
- Divide: restoring, one quotient bit per CALC cycle.
  - FIX negates the quotient when the signs differ (signed op only). It gives the remainder the sign of the dividend.
  - LO = quotient, HI = remainder.
- Divide by zero (rt == 0): LO = 0xFFFFFFFF and HI = rs (original value), with no sign fix. Latency is still the full count.
- Overflow case: 0x80000000 / 0xFFFFFFFF (signed) gives LO = 0x80000000, HI = 0. This falls out of the magnitude arithmetic.
- `stall` is asserted while `busy` is 1 and any of the eight strobes is asserted. The pipeline re-presents the held strobe each cycle.
- `mfhi`/`mflo` in IDLE read the committed HI/LO with no stall.
- Unrelated instructions proceed while `busy`. There is no stall without a strobe.

## Timing
- Reset (`rst` = 0, asynchronous):
  - `hi` = 0, `lo` = 0, `busy` = 0.
  - State IDLE, counter 0.
  - Any in-flight operation is discarded.
  - `stall` = 0 while no strobe is asserted.
- A start strobe sampled at edge E0:
  - `busy` = 1 from E0.
  - CALC covers edges E1..E32.
  - FIX commits HI/LO at edge E33, and `busy` = 0 after E33.
  - A strobe held while stalled is accepted at E33 if it is a start or move, or read from E33 if it is a read.
- A held `mfhi` that stalled during the operation reads the new HI in the cycle after E33, with `stall` = 0.
- `mthi`/`mtlo` update takes effect at the sampling edge. A `mfhi` in the following cycle returns the new value.
- Simultaneous move and read in one cycle (illegal encoding): the move commits and the read returns the old value.
- Back-to-back starts: the second start is accepted at E33 and is busy for a further 33 cycles. No idle bubble is required.

## Test plan
- Reset mid-operation: start `mult` rs=5, rt=7, deassert `rst` at E10 and release it. Required: `hi`=`lo`=0, `busy`=0, no late commit at E33.
- Signed multiply: `mult` rs=0xFFFFFFFD (−3), rt=7, then hold `mflo`. Required:
  - `stall`=1 through E33.
  - HI=0xFFFFFFFF, LO=0xFFFFFFEB.
  - `hilo_rdata`=0xFFFFFFEB the cycle after E33.
- Unsigned multiply: `multu` 0xFFFFFFFF × 0xFFFFFFFF. Required: HI=0xFFFFFFFE, LO=0x00000001 at E33.
- Signed divide: `div` −7 / 2. Required: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Unsigned divide: `divu` 100/7. Required: LO=14, HI=2.
- Divide by zero: `div` 0x1234 / 0. Required: LO=0xFFFFFFFF, HI=0x1234, `busy` for exactly 33 cycles.
- Moves and arbitration:
  - `mthi` 0xA5A5A5A5 then `mfhi` the next cycle returns 0xA5A5A5A5 with `stall`=0.
  - `mtlo` during `busy` stalls until E33, then writes LO.
  - `mult` and `mthi` asserted together in IDLE: only the multiply starts.
